mdu: RTL and testbench

Multiply/divide unit for the EX stage of the pipelined MIPS core, sitting beside the ALU and fed by the same forwarded operands. It executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes, and holds the architectural HI/LO registers. The hazard unit stalls on its `busy` output, and the EX result mux reads HI/LO directly for mfhi/mflo.

---
 rtl/mdu.sv | 170 +++++++++++++++++
 tb/tb_mdu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO for the EX stage.
// Multi-cycle MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
// Optional macro MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (codes 7-10).
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_t;

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    state_t      state, state_d;
    logic [4:0]  cnt, cnt_d;
    logic [63:0] shadow, shadow_d;
    logic        wr, wr_d;

    logic        is_multi, is_div, is_mt;
    logic        done, accept;

    logic [63:0] prod_s, prod_u;
    logic [31:0] udiv_b, uq, ur;
    logic [31:0] mag_a, mag_b, mq, mr, sq, sr;
`ifdef MDU_MADD_EN
    logic [63:0] base;
`endif

    // Decode the operation class; unknown codes fall through as NONE
    always_comb begin
        is_multi = 1'b0;
        is_div   = 1'b0;
        is_mt    = 1'b0;
        case (MDUOp)
            OP_MULT, OP_MULTU: is_multi = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_multi = 1'b1;
                is_div   = 1'b1;
            end
            OP_MTHI, OP_MTLO: is_mt = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_multi = 1'b1;
`endif
            default: ;
        endcase
    end

    // The completing edge of a RUN also accepts a new op, so issue is back-to-back
    assign done   = (state == RUN) && (cnt == 5'd1);
    assign accept = start && !flush && (is_multi || is_mt) && ((state == IDLE) || done);
    assign busy   = (state == RUN);

    // Multiply and divide datapath; divisor forced to 1 on zero to keep results defined
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'h0, A} * {32'h0, B};
        udiv_b = (B == 32'h0) ? 32'd1 : B;
        uq     = A / udiv_b;
        ur     = A % udiv_b;
        mag_a  = A[31] ? -A : A;
        mag_b  = (B == 32'h0) ? 32'd1 : (B[31] ? -B : B);
        mq     = mag_a / mag_b;
        mr     = mag_a % mag_b;
        // Sign fix-up on magnitudes also yields 0x80000000 for MIN/-1
        sq     = (A[31] ^ B[31]) ? -mq : mq;
        sr     = A[31] ? -mr : mr;
    end

`ifdef MDU_MADD_EN
    // Accumulate from the architectural value as it stands after this edge's retirement
    assign base = (done && wr) ? shadow : {HI, LO};
`endif

    // Select the result captured into the shadow register at accept
    always_comb begin
        shadow_d = shadow;
        wr_d     = 1'b1;
        case (MDUOp)
            OP_MULT:  shadow_d = prod_s;
            OP_MULTU: shadow_d = prod_u;
            OP_DIV: begin
                shadow_d = {sr, sq};
                wr_d     = (B != 32'h0);
            end
            OP_DIVU: begin
                shadow_d = {ur, uq};
                wr_d     = (B != 32'h0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  shadow_d = base + prod_s;
            OP_MADDU: shadow_d = base + prod_u;
            OP_MSUB:  shadow_d = base - prod_s;
            OP_MSUBU: shadow_d = base - prod_u;
`endif
            default: ;
        endcase
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (state == RUN) begin
            cnt_d = cnt - 5'd1;
            if (done) state_d = IDLE;
        end
        if (accept && is_multi) begin
            state_d = RUN;
            cnt_d   = is_div ? DIV_N : MULT_N;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // HI/LO and shadow registers; an MTHI/MTLO on a completing edge overrides the retiring half
    always_ff @(posedge clk) begin
        if (!reset) begin
            HI     <= '0;
            LO     <= '0;
            shadow <= '0;
            wr     <= 1'b0;
        end else begin
            if (done && wr) {HI, LO} <= shadow;
            if (accept) begin
                if (is_mt) begin
                    if (MDUOp == OP_MTHI) HI <= A;
                    else                  LO <= A;
                end else begin
                    shadow <= shadow_d;
                    wr     <= wr_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard-based bench for mdu.
module tb_mdu;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        start, flush;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi, m_lo;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
        .start(start), .flush(flush), .busy(busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: new {HI,LO} after the op completes
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        int          sa = a;
        int          sb = b;
        longint      ps;
        logic [63:0] pu;
        ps = longint'(sa) * longint'(sb);
        pu = {32'h0, a} * {32'h0, b};
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 32'h0) return {hi, lo};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'h0) return {hi, lo};
                return {a % b, a / b};
            end
            4'd7:  return {hi, lo} + 64'(ps);
            4'd8:  return {hi, lo} + pu;
            4'd9:  return {hi, lo} - 64'(ps);
            4'd10: return {hi, lo} - pu;
            default: return {hi, lo};
        endcase
    endfunction

    // Push the expected completion of a multi-cycle op and advance the model
    task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        r = model(op, a, b, m_hi, m_lo);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.cyc = (op == 4'd3 || op == 4'd4) ? int'(DC) : int'(MC);
        {m_hi, m_lo} = r;
        sbq.push_back(e);
    endtask

    // Present one op for one edge (called at a negedge), then scramble operands
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        MDUOp = op; A = a; B = b; flush = fl; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; MDUOp = 4'd0;
        A = $urandom; B = $urandom;
    endtask

    // Count busy cycles, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", HI, 32'h0); end
        total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", LO, 32'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        issue(4'd5, 32'hAAAA5555, 32'h0, 1'b0); m_hi = 32'hAAAA5555;
        issue(4'd6, 32'h13579BDF, 32'h0, 1'b0); m_lo = 32'h13579BDF;
        total++; if ({HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL mt_preload got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo); end
        // DIV, then reset during its third busy cycle
        issue(4'd3, 32'd100, 32'd3, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL div_busy_before_reset got=%b exp=1", busy); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_reset_busy got=%b exp=0", busy); end
        total++; if ({HI, LO} !== 64'h0) begin bad++; $display("FAIL midrun_reset_hilo got=%h_%h exp=0", HI, LO); end
        repeat (DC + 2) @(negedge clk);
        total++; if ({busy, HI, LO} !== 65'h0) begin bad++; $display("FAIL aborted_discard got=%b %h_%h exp=0", busy, HI, LO); end
        wait_idle(n);
    endtask

    task automatic run_multi(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int   n;
        exp_t e;
        push_exp(op, a, b);
        issue(op, a, b, 1'b0);
        wait_idle(n);
        e = sbq.pop_front();
        total++; if (n !== e.cyc) begin bad++; $display("FAIL %s_cycles got=%0d exp=%0d", name, n, e.cyc); end
        total++; if ({HI, LO} !== {e.hi, e.lo}) begin bad++; $display("FAIL %s_result got=%h_%h exp=%h_%h", name, HI, LO, e.hi, e.lo); end
    endtask

    task automatic test_mult();
        run_multi("mult", 4'd1, 32'hFFFFFFFE, 32'd3);
        run_multi("multu", 4'd2, 32'hFFFFFFFE, 32'd3);
        run_multi("mult_rand", 4'd1, $urandom, $urandom);
    endtask

    task automatic test_div();
        run_multi("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2);
        run_multi("divu_zero", 4'd4, 32'd7, 32'd0);
        run_multi("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
        run_multi("div_rand", 4'd3, $urandom, $urandom_range(1, 1000));
        run_multi("divu_rand", 4'd4, $urandom, $urandom_range(1, 1000));
    endtask

    task automatic test_flush_start();
        int   n;
        exp_t e;
        issue(4'd5, 32'h12345678, 32'h0, 1'b1);
        total++; if (HI !== m_hi) begin bad++; $display("FAIL mthi_flush got=%h exp=%h", HI, m_hi); end
        issue(4'd6, 32'hCAFEBABE, 32'h0, 1'b0); m_lo = 32'hCAFEBABE;
        total++; if (LO !== 32'hCAFEBABE || busy !== 1'b0) begin bad++; $display("FAIL mtlo got=%h busy=%b exp=%h busy=0", LO, busy, 32'hCAFEBABE); end
        issue(4'd5, 32'h0BADF00D, 32'h0, 1'b0); m_hi = 32'h0BADF00D;
        total++; if (HI !== 32'h0BADF00D || busy !== 1'b0) begin bad++; $display("FAIL mthi got=%h busy=%b exp=%h busy=0", HI, busy, 32'h0BADF00D); end
        // start in mid-RUN is ignored
        push_exp(4'd1, 32'd3, 32'd5);
        issue(4'd1, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        issue(4'd3, 32'd9, 32'd3, 1'b0);
        wait_idle(n);
        e = sbq.pop_front();
        total++; if (n !== int'(MC) - 2) begin bad++; $display("FAIL start_in_run_cycles got=%0d exp=%0d", n, int'(MC) - 2); end
        total++; if ({HI, LO} !== {e.hi, e.lo}) begin bad++; $display("FAIL start_in_run_result got=%h_%h exp=%h_%h", HI, LO, e.hi, e.lo); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || {HI, LO} !== {e.hi, e.lo}) begin bad++; $display("FAIL start_in_run_stays got=%b %h_%h exp=0 %h_%h", busy, HI, LO, e.hi, e.lo); end
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        push_exp(4'd1, 32'd6, 32'd7);
        issue(4'd1, 32'd6, 32'd7, 1'b0);
        repeat (MC - 1) @(negedge clk);
        // Last busy cycle of the MULT: present DIVU for the completing edge
        push_exp(4'd4, 32'd100, 32'd7);
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        e = sbq.pop_front();
        total++; if ({HI, LO} !== {e.hi, e.lo}) begin bad++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", HI, LO, e.hi, e.lo); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy got=%b exp=1", busy); end
        wait_idle(n);
        e = sbq.pop_front();
        total++; if (n !== e.cyc) begin bad++; $display("FAIL b2b_second_cycles got=%0d exp=%0d", n, e.cyc); end
        total++; if ({HI, LO} !== {e.hi, e.lo}) begin bad++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", HI, LO, e.hi, e.lo); end
        // flush while running does not cancel
        push_exp(4'd2, 32'h00010000, 32'h00010000);
        issue(4'd2, 32'h00010000, 32'h00010000, 1'b0);
        flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        wait_idle(n);
        e = sbq.pop_front();
        total++; if ({HI, LO} !== {e.hi, e.lo} || n !== int'(MC) - 2) begin bad++; $display("FAIL flush_in_run got=%h_%h n=%0d exp=%h_%h n=%0d", HI, LO, n, e.hi, e.lo, int'(MC) - 2); end
    endtask

    task automatic test_madd();
        int n;
        issue(4'd5, 32'h0, 32'h0, 1'b0);        m_hi = 32'h0;
        issue(4'd6, 32'hFFFFFFFF, 32'h0, 1'b0); m_lo = 32'hFFFFFFFF;
`ifdef MDU_MADD_EN
        run_multi("maddu", 4'd8, 32'd1, 32'd1);
        total++; if ({HI, LO} !== 64'h1_00000000) begin bad++; $display("FAIL maddu_const got=%h_%h exp=00000001_00000000", HI, LO); end
        run_multi("msub", 4'd9, 32'hFFFFFFFF, 32'd5);
        run_multi("madd_rand", 4'd7, $urandom, $urandom);
        run_multi("msubu_rand", 4'd10, $urandom, $urandom);
`else
        issue(4'd8, 32'd1, 32'd1, 1'b0);
        total++; if (busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL maddu_disabled got=%b %h_%h exp=0 %h_%h", busy, HI, LO, m_hi, m_lo); end
`endif
        issue(4'd15, 32'd9, 32'd9, 1'b0);
        total++; if (busy !== 1'b0 || {HI, LO} !== {m_hi, m_lo}) begin bad++; $display("FAIL invalid_code got=%b %h_%h exp=0 %h_%h", busy, HI, LO, m_hi, m_lo); end
        wait_idle(n);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        MDUOp = 4'd0; A = '0; B = '0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_flush_start();
        test_back_to_back();
        test_madd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
